// File: rtl/transmit_packet_1_if.sv
// Bus bundle for the packet replay stage: the Avalon-MM read master towards
// the shared packet RAM and the Avalon-ST transmit stream towards the MAC.
interface transmit_packet_1_if #(
   parameter int ADDR_W = 10
);
   // Avalon-MM read master side
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_chipselect;
   logic              ram_read;
   logic [31:0]       ram_readdata;
   logic              ram_waitrequest;

   // Avalon-ST transmit side
   logic [7:0]        ff_tx_data;
   logic              ff_tx_sop;
   logic              ff_tx_eop;
   logic              ff_tx_wren;
   logic              ff_tx_err;
   logic              ff_tx_crc_fwd;
   logic              ff_tx_rdy;

   // Replay block drives the read requests and the transmit stream
   modport master (
      output ram_addr, ram_chipselect, ram_read,
      input  ram_readdata, ram_waitrequest,
      output ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_wren, ff_tx_err, ff_tx_crc_fwd,
      input  ff_tx_rdy
   );

   // RAM and MAC side of the same bundle
   modport slave (
      input  ram_addr, ram_chipselect, ram_read,
      output ram_readdata, ram_waitrequest,
      input  ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_wren, ff_tx_err, ff_tx_crc_fwd,
      output ff_tx_rdy
   );
endinterface

// File: rtl/transmit_packet_1.sv
// Packet replay stage of the loopback path. Once the receive stage reports a
// stored packet, the length word and payload words are read from the shared
// RAM one at a time and the payload is streamed MSB byte first to the MAC.
// Every output is taken straight from a flop.
module transmit_packet_1 #(
   parameter int ADDR_W    = 10,
   parameter int MAX_BYTES = 4092
) (
   input  logic                 clk_original,
   input  logic                 rst,
   input  logic                 data_saved,
   transmit_packet_1_if.master  bus,
   output logic                 tx_done,
   output logic                 len_err,
   output logic                 busy
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_LEN  = 3'd1,
      S_RD_WORD = 3'd2,
      S_SEND    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   // Registered state and outputs
   state_t            r_state;
   logic              r_pending;
   logic [15:0]       r_remaining;
   logic [1:0]        r_idx;
   logic [31:0]       r_shift;
   logic [ADDR_W-1:0] r_addr;
   logic              r_read;
   logic [7:0]        r_data;
   logic              r_sop;
   logic              r_eop;
   logic              r_wren;
   logic              r_tx_done;
   logic              r_len_err;
   logic              r_busy;

   // Next-state values
   state_t            w_state_nxt;
   logic              w_pending_nxt;
   logic [15:0]       w_remaining_nxt;
   logic [1:0]        w_idx_nxt;
   logic [31:0]       w_shift_nxt;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic              w_read_nxt;
   logic [7:0]        w_data_nxt;
   logic              w_sop_nxt;
   logic              w_eop_nxt;
   logic              w_wren_nxt;
   logic              w_tx_done_nxt;
   logic              w_len_err_nxt;
   logic              w_busy_nxt;

   // Handshake qualifiers
   logic              w_capture;
   logic              w_xfer;
   logic [15:0]       w_len;
   logic              w_len_bad;

   assign w_capture = r_read & ~bus.ram_waitrequest;
   assign w_xfer    = r_wren & bus.ff_tx_rdy;
   assign w_len     = bus.ram_readdata[15:0];
   assign w_len_bad = (w_len == 16'd0) || (w_len > 16'(MAX_BYTES));

   // Next-state and next-output decode for the replay sequencer
   always_comb begin
      w_state_nxt     = r_state;
      w_pending_nxt   = r_pending;
      w_remaining_nxt = r_remaining;
      w_idx_nxt       = r_idx;
      w_shift_nxt     = r_shift;
      w_addr_nxt      = r_addr;
      w_read_nxt      = r_read;
      w_data_nxt      = r_data;
      w_sop_nxt       = r_sop;
      w_eop_nxt       = r_eop;
      w_wren_nxt      = r_wren;
      w_tx_done_nxt   = 1'b0;
      w_len_err_nxt   = 1'b0;

      // A request arriving while a packet is in flight is remembered once
      if (data_saved && (r_state != S_IDLE)) begin
         w_pending_nxt = 1'b1;
      end else begin
         w_pending_nxt = r_pending;
      end

      case (r_state)
         S_IDLE: begin
            if (data_saved || r_pending) begin
               w_state_nxt   = S_RD_LEN;
               w_addr_nxt    = {ADDR_W{1'b0}};
               w_read_nxt    = 1'b1;
               w_pending_nxt = 1'b0;
            end else begin
               w_state_nxt   = S_IDLE;
            end
         end

         S_RD_LEN: begin
            if (!r_read) begin
               w_read_nxt = 1'b1;
            end else if (w_capture) begin
               w_read_nxt = 1'b0;
               if (w_len_bad) begin
                  w_len_err_nxt = 1'b1;
                  w_state_nxt   = S_IDLE;
               end else begin
                  w_remaining_nxt = w_len;
                  w_addr_nxt      = ADDR_W'(1);
                  w_state_nxt     = S_RD_WORD;
               end
            end else begin
               w_read_nxt = r_read;
            end
         end

         S_RD_WORD: begin
            // Read is raised one cycle after the previous capture so that
            // ram_read always drops between two word reads
            if (!r_read) begin
               w_read_nxt = 1'b1;
            end else if (w_capture) begin
               w_read_nxt  = 1'b0;
               w_shift_nxt = bus.ram_readdata;
               w_idx_nxt   = 2'd0;
               w_data_nxt  = bus.ram_readdata[31:24];
               // Payload starts at word 1, so only that word carries sop
               w_sop_nxt   = (r_addr == ADDR_W'(1));
               w_eop_nxt   = (r_remaining == 16'd1);
               w_wren_nxt  = 1'b1;
               w_state_nxt = S_SEND;
            end else begin
               w_read_nxt = r_read;
            end
         end

         S_SEND: begin
            if (w_xfer) begin
               w_remaining_nxt = r_remaining - 16'd1;
               w_idx_nxt       = r_idx + 2'd1;
               if (r_remaining == 16'd1) begin
                  w_wren_nxt    = 1'b0;
                  w_sop_nxt     = 1'b0;
                  w_eop_nxt     = 1'b0;
                  w_tx_done_nxt = 1'b1;
                  w_state_nxt   = S_DONE;
               end else if (r_idx == 2'd3) begin
                  w_wren_nxt  = 1'b0;
                  w_sop_nxt   = 1'b0;
                  w_eop_nxt   = 1'b0;
                  w_addr_nxt  = r_addr + ADDR_W'(1);
                  w_state_nxt = S_RD_WORD;
               end else begin
                  w_shift_nxt = {r_shift[23:0], 8'h00};
                  w_data_nxt  = r_shift[23:16];
                  w_sop_nxt   = 1'b0;
                  w_eop_nxt   = (r_remaining == 16'd2);
               end
            end else begin
               // MAC stall: the presented byte and flags stay untouched
               w_state_nxt = S_SEND;
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_read_nxt  = 1'b0;
            w_wren_nxt  = 1'b0;
            w_sop_nxt   = 1'b0;
            w_eop_nxt   = 1'b0;
         end
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // State and output registers; reset aborts any packet in flight
   always_ff @(posedge clk_original or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_pending   <= 1'b0;
         r_remaining <= 16'd0;
         r_idx       <= 2'd0;
         r_shift     <= 32'd0;
         r_addr      <= {ADDR_W{1'b0}};
         r_read      <= 1'b0;
         r_data      <= 8'd0;
         r_sop       <= 1'b0;
         r_eop       <= 1'b0;
         r_wren      <= 1'b0;
         r_tx_done   <= 1'b0;
         r_len_err   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pending   <= w_pending_nxt;
         r_remaining <= w_remaining_nxt;
         r_idx       <= w_idx_nxt;
         r_shift     <= w_shift_nxt;
         r_addr      <= w_addr_nxt;
         r_read      <= w_read_nxt;
         r_data      <= w_data_nxt;
         r_sop       <= w_sop_nxt;
         r_eop       <= w_eop_nxt;
         r_wren      <= w_wren_nxt;
         r_tx_done   <= w_tx_done_nxt;
         r_len_err   <= w_len_err_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   assign bus.ram_addr       = r_addr;
   assign bus.ram_read       = r_read;
   assign bus.ram_chipselect = r_read;
   assign bus.ff_tx_data     = r_data;
   assign bus.ff_tx_sop      = r_sop;
   assign bus.ff_tx_eop      = r_eop;
   assign bus.ff_tx_wren     = r_wren;
   assign bus.ff_tx_err      = 1'b0;
   assign bus.ff_tx_crc_fwd  = 1'b0;
   assign tx_done            = r_tx_done;
   assign len_err            = r_len_err;
   assign busy               = r_busy;

endmodule
